// File: rtl/msi_cache_controller_if.sv
// Signal bundle between the MSI cache controller, its CPU port, the shared snooping bus
// and the line-state debug display.
interface msi_cache_controller_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
);
    logic                   cpu_req;
    logic                   cpu_write;
    logic [ADDR_WIDTH-1:0]  cpu_addr;
    logic                   cpu_ready;
    logic                   cpu_hit;

    logic                   bus_req;
    logic [1:0]             bus_cmd;
    logic [ADDR_WIDTH-1:0]  bus_addr;
    logic                   bus_grant;

    logic                   snoop_valid;
    logic [1:0]             snoop_cmd;
    logic [ADDR_WIDTH-1:0]  snoop_addr;

    logic                   write_back;
    logic                   abort_mem;
    logic [ADDR_WIDTH-1:0]  wb_addr;

    logic [INDEX_WIDTH-1:0] dbg_index;
    logic [1:0]             dbg_state;

    modport master (
        output cpu_req, cpu_write, cpu_addr, bus_grant,
               snoop_valid, snoop_cmd, snoop_addr, dbg_index,
        input  cpu_ready, cpu_hit, bus_req, bus_cmd, bus_addr,
               write_back, abort_mem, wb_addr, dbg_state
    );

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, bus_grant,
               snoop_valid, snoop_cmd, snoop_addr, dbg_index,
        output cpu_ready, cpu_hit, bus_req, bus_cmd, bus_addr,
               write_back, abort_mem, wb_addr, dbg_state
    );
endinterface

// File: rtl/msi_cache_controller.sv
// MSI coherence controller for a direct-mapped cache: CPU-side and snoop-side state
// machines merged into one clocked block, with bus request/grant and victim eviction.
module msi_cache_controller #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    msi_cache_controller_if.slave cache_if
);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_INV  = 2'b11;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EVICT    = 2'd1;
    localparam logic [1:0] BUS_WAIT = 2'd2;

    logic [1:0]             line_state [LINES];
    logic [TAG_WIDTH-1:0]   line_tag   [LINES];
    logic [1:0]             fsm;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   req_write;

    logic [INDEX_WIDTH-1:0] snoop_index;
    logic [TAG_WIDTH-1:0]   snoop_tag;
    logic                   snoop_match;
    logic                   snoop_wb;
    logic [1:0]             snoop_next;

    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [INDEX_WIDTH-1:0] cur_index;
    logic [TAG_WIDTH-1:0]   cur_tag;
    logic [1:0]             cur_state;
    logic                   cur_hit;
    logic [1:0]             miss_cmd;

    always_comb begin
        snoop_index = cache_if.snoop_addr[INDEX_WIDTH-1:0];
        snoop_tag   = cache_if.snoop_addr[ADDR_WIDTH-1:INDEX_WIDTH];
        snoop_match = cache_if.snoop_valid && (line_state[snoop_index] != ST_I) &&
                      (line_tag[snoop_index] == snoop_tag);
        snoop_next  = line_state[snoop_index];
        snoop_wb    = 1'b0;
        if (snoop_match) begin
            case (cache_if.snoop_cmd)
                CMD_RD: begin
                    if (line_state[snoop_index] == ST_M) begin
                        snoop_next = ST_S;
                        snoop_wb   = 1'b1;
                    end
                end
                CMD_WR: begin
                    snoop_next = ST_I;
                    snoop_wb   = (line_state[snoop_index] == ST_M);
                end
                CMD_INV: snoop_next = ST_I;
                default: snoop_next = line_state[snoop_index];
            endcase
        end
    end

    // The CPU-side decision always sees the line as it stands after this cycle's snoop.
    always_comb begin
        cur_addr  = (fsm == IDLE) ? cache_if.cpu_addr : req_addr;
        cur_index = cur_addr[INDEX_WIDTH-1:0];
        cur_tag   = cur_addr[ADDR_WIDTH-1:INDEX_WIDTH];
        cur_state = (snoop_match && (snoop_index == cur_index)) ? snoop_next : line_state[cur_index];
        cur_hit   = (cur_state != ST_I) && (line_tag[cur_index] == cur_tag);
        miss_cmd  = ((fsm == IDLE) ? cache_if.cpu_write : req_write) ? CMD_WR : CMD_RD;
    end

    assign cache_if.dbg_state = line_state[cache_if.dbg_index];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LINES; i++) begin
                line_state[i] <= ST_I;
                line_tag[i]   <= '0;
            end
            fsm                 <= IDLE;
            req_addr            <= '0;
            req_write           <= 1'b0;
            cache_if.cpu_ready  <= 1'b0;
            cache_if.cpu_hit    <= 1'b0;
            cache_if.bus_req    <= 1'b0;
            cache_if.bus_cmd    <= CMD_NONE;
            cache_if.bus_addr   <= '0;
            cache_if.write_back <= 1'b0;
            cache_if.abort_mem  <= 1'b0;
            cache_if.wb_addr    <= '0;
        end else begin
            cache_if.cpu_ready  <= 1'b0;
            cache_if.cpu_hit    <= 1'b0;
            cache_if.write_back <= 1'b0;
            cache_if.abort_mem  <= 1'b0;
            if (snoop_match) begin
                line_state[snoop_index] <= snoop_next;
                if (snoop_wb) begin
                    cache_if.write_back <= 1'b1;
                    cache_if.abort_mem  <= 1'b1;
                    cache_if.wb_addr    <= cache_if.snoop_addr;
                end
            end
            case (fsm)
                IDLE: begin
                    if (cache_if.cpu_req) begin
                        req_addr  <= cache_if.cpu_addr;
                        req_write <= cache_if.cpu_write;
                        if (cur_hit && (!cache_if.cpu_write || cur_state == ST_M)) begin
                            cache_if.cpu_ready <= 1'b1;
                            cache_if.cpu_hit   <= 1'b1;
                        end else if (!cur_hit && cur_state == ST_M) begin
                            fsm <= EVICT;
                        end else begin
                            cache_if.bus_req  <= 1'b1;
                            cache_if.bus_cmd  <= cur_hit ? CMD_INV : miss_cmd;
                            cache_if.bus_addr <= cache_if.cpu_addr;
                            fsm               <= BUS_WAIT;
                        end
                    end
                end
                // A snoop write-back owns the write-back port this cycle, so the eviction waits.
                EVICT: begin
                    if (!snoop_wb) begin
                        if (cur_state == ST_M) begin
                            cache_if.write_back <= 1'b1;
                            cache_if.wb_addr    <= {line_tag[cur_index], cur_index};
                        end
                        cache_if.bus_req  <= 1'b1;
                        cache_if.bus_cmd  <= miss_cmd;
                        cache_if.bus_addr <= req_addr;
                        fsm               <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    if (cache_if.bus_grant) begin
                        line_state[cur_index] <= (cache_if.bus_cmd == CMD_RD) ? ST_S : ST_M;
                        line_tag[cur_index]   <= cur_tag;
                        cache_if.cpu_ready    <= 1'b1;
                        cache_if.bus_req      <= 1'b0;
                        cache_if.bus_cmd      <= CMD_NONE;
                        fsm                   <= IDLE;
                    end else if (cache_if.bus_cmd == CMD_INV && cur_state == ST_I) begin
                        cache_if.bus_cmd <= CMD_WR;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msi_cache_controller.sv
// Directed and randomized checks of msi_cache_controller against a per-line MSI model
// kept as plain state/tag arrays updated from the coherence rules.
module tb_msi_cache_controller;
    localparam int ADDR_WIDTH  = 8;
    localparam int INDEX_WIDTH = 2;
    localparam int LINES       = 4;

    localparam int MS_I = 0;
    localparam int MS_S = 1;
    localparam int MS_M = 2;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_INV  = 2'b11;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   m_state [LINES];
    int   m_tag   [LINES];

    msi_cache_controller_if #(.ADDR_WIDTH(ADDR_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) cache_if ();

    msi_cache_controller #(.ADDR_WIDTH(ADDR_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cache_if (cache_if)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit model_hit(input int addr);
        return (m_state[addr % LINES] != MS_I) && (m_tag[addr % LINES] == addr / LINES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_state[i] = MS_I;
            m_tag[i]   = 0;
        end
    endtask

    task automatic check_line(input int idx);
        cache_if.dbg_index = INDEX_WIDTH'(idx);
        #1;
        check($sformatf("dbg_state[%0d]", idx), {30'd0, cache_if.dbg_state}, m_state[idx]);
    endtask

    task automatic grant_and_finish(input int idx, input int tag_value, input int new_state);
        cache_if.bus_grant = 1'b1;
        tick();
        cache_if.bus_grant = 1'b0;
        check("grant_ready", cache_if.cpu_ready, 1);
        check("grant_hit", cache_if.cpu_hit, 0);
        check("grant_bus_req", cache_if.bus_req, 0);
        check("grant_bus_cmd", cache_if.bus_cmd, CMD_NONE);
        m_state[idx] = new_state;
        m_tag[idx]   = tag_value;
        check_line(idx);
    endtask

    task automatic cpu_access(input bit write, input logic [7:0] addr);
        int         idx;
        int         wb_seen;
        int         waited;
        int         stall;
        bit         hit;
        bit         exp_wb;
        logic [1:0] exp_cmd;
        logic [7:0] victim;
        idx    = int'(addr) % LINES;
        hit    = model_hit(int'(addr));
        exp_wb = !hit && (m_state[idx] == MS_M);
        victim = 8'(m_tag[idx] * LINES + idx);
        cache_if.cpu_req   = 1'b1;
        cache_if.cpu_write = write;
        cache_if.cpu_addr  = addr;
        tick();
        cache_if.cpu_req = 1'b0;
        if (hit && (!write || m_state[idx] == MS_M)) begin
            check("hit_ready", cache_if.cpu_ready, 1);
            check("hit_flag", cache_if.cpu_hit, 1);
            check("hit_no_bus", cache_if.bus_req, 0);
        end else begin
            exp_cmd = hit ? CMD_INV : (write ? CMD_WR : CMD_RD);
            wb_seen = 0;
            waited  = 0;
            forever begin
                if (cache_if.write_back === 1'b1) begin
                    wb_seen++;
                    check("evict_wb_addr", cache_if.wb_addr, victim);
                    check("evict_no_abort", cache_if.abort_mem, 0);
                end
                if (cache_if.bus_req === 1'b1 || waited >= 8) break;
                tick();
                waited++;
            end
            check("bus_req_rise", cache_if.bus_req, 1);
            check("evict_count", wb_seen, 32'(exp_wb));
            check("bus_cmd", cache_if.bus_cmd, exp_cmd);
            check("bus_addr", cache_if.bus_addr, addr);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                cache_if.cpu_req   = 1'b1;
                cache_if.cpu_write = 1'($urandom_range(0, 1));
                cache_if.cpu_addr  = 8'($urandom_range(0, 255));
                tick();
                check("stall_bus_req", cache_if.bus_req, 1);
                check("stall_bus_cmd", cache_if.bus_cmd, exp_cmd);
                check("stall_no_ready", cache_if.cpu_ready, 0);
            end
            cache_if.cpu_req = 1'b0;
            grant_and_finish(idx, int'(addr) / LINES, write ? MS_M : MS_S);
        end
        check_line(idx);
    endtask

    task automatic snoop(input logic [1:0] cmd, input logic [7:0] addr);
        int idx;
        bit match;
        bit exp_wb;
        idx    = int'(addr) % LINES;
        match  = model_hit(int'(addr));
        exp_wb = match && (m_state[idx] == MS_M) && (cmd == CMD_RD || cmd == CMD_WR);
        cache_if.snoop_valid = 1'b1;
        cache_if.snoop_cmd   = cmd;
        cache_if.snoop_addr  = addr;
        tick();
        cache_if.snoop_valid = 1'b0;
        check("snoop_wb", cache_if.write_back, 32'(exp_wb));
        check("snoop_abort", cache_if.abort_mem, 32'(exp_wb));
        if (exp_wb) check("snoop_wb_addr", cache_if.wb_addr, addr);
        if (match) begin
            if (cmd == CMD_RD && m_state[idx] == MS_M) m_state[idx] = MS_S;
            else if (cmd == CMD_WR || cmd == CMD_INV) m_state[idx] = MS_I;
        end
        check_line(idx);
    endtask

    initial begin
        int wb_seen;
        int waited;
        int ready_seen;
        logic [7:0] a;

        cache_if.cpu_req     = 1'b0;
        cache_if.cpu_write   = 1'b0;
        cache_if.cpu_addr    = '0;
        cache_if.bus_grant   = 1'b0;
        cache_if.snoop_valid = 1'b0;
        cache_if.snoop_cmd   = CMD_NONE;
        cache_if.snoop_addr  = '0;
        cache_if.dbg_index   = '0;
        model_reset();

        // Reset state
        #12;
        check("reset_ready", cache_if.cpu_ready, 0);
        check("reset_bus_req", cache_if.bus_req, 0);
        check("reset_bus_cmd", cache_if.bus_cmd, CMD_NONE);
        check("reset_wb", cache_if.write_back, 0);
        check("reset_abort", cache_if.abort_mem, 0);
        for (int i = 0; i < LINES; i++) check_line(i);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Read miss then read hit on 0x15
        cpu_access(1'b0, 8'h15);
        cpu_access(1'b0, 8'h15);

        // Upgrade S->M, then snoop read miss supplies the data
        cpu_access(1'b1, 8'h15);
        snoop(CMD_RD, 8'h15);

        // Victim in M is written back before the read miss for 0x25
        cpu_access(1'b1, 8'h15);
        cpu_access(1'b0, 8'h25);
        cpu_access(1'b0, 8'h25);

        // Upgrade lost to a snoop write miss turns into a write miss
        cpu_access(1'b0, 8'h15);
        cache_if.cpu_req   = 1'b1;
        cache_if.cpu_write = 1'b1;
        cache_if.cpu_addr  = 8'h15;
        tick();
        cache_if.cpu_req = 1'b0;
        check("upg_bus_req", cache_if.bus_req, 1);
        check("upg_cmd", cache_if.bus_cmd, CMD_INV);
        cache_if.snoop_valid = 1'b1;
        cache_if.snoop_cmd   = CMD_WR;
        cache_if.snoop_addr  = 8'h15;
        tick();
        cache_if.snoop_valid = 1'b0;
        check("upg_lost_cmd", cache_if.bus_cmd, CMD_WR);
        check("upg_lost_no_wb", cache_if.write_back, 0);
        m_state[1] = MS_I;
        check_line(1);
        grant_and_finish(1, 8'h15 / LINES, MS_M);

        // Snoop read miss hits the M victim during eviction: one write-back only
        cache_if.cpu_req   = 1'b1;
        cache_if.cpu_write = 1'b0;
        cache_if.cpu_addr  = 8'h25;
        tick();
        cache_if.cpu_req = 1'b0;
        check("evict_wait_bus_req", cache_if.bus_req, 0);
        cache_if.snoop_valid = 1'b1;
        cache_if.snoop_cmd   = CMD_RD;
        cache_if.snoop_addr  = 8'h15;
        tick();
        cache_if.snoop_valid = 1'b0;
        check("evict_snoop_wb", cache_if.write_back, 1);
        check("evict_snoop_abort", cache_if.abort_mem, 1);
        check("evict_snoop_wb_addr", cache_if.wb_addr, 8'h15);
        check("evict_snoop_held", cache_if.bus_req, 0);
        wb_seen = 0;
        waited  = 0;
        while (cache_if.bus_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
            if (cache_if.write_back === 1'b1) wb_seen++;
        end
        check("evict_snoop_bus_req", cache_if.bus_req, 1);
        check("evict_snoop_second_wb", wb_seen, 0);
        check("evict_snoop_cmd", cache_if.bus_cmd, CMD_RD);
        check("evict_snoop_addr", cache_if.bus_addr, 8'h25);
        grant_and_finish(1, 8'h25 / LINES, MS_S);

        // Asynchronous reset in the middle of a bus wait
        cache_if.cpu_req   = 1'b1;
        cache_if.cpu_write = 1'b0;
        cache_if.cpu_addr  = 8'h3A;
        tick();
        cache_if.cpu_req = 1'b0;
        check("rst_pending_bus_req", cache_if.bus_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_bus_req", cache_if.bus_req, 0);
        check("rst_async_bus_cmd", cache_if.bus_cmd, CMD_NONE);
        model_reset();
        for (int i = 0; i < LINES; i++) check_line(i);
        @(negedge clock);
        reset_n    = 1'b1;
        ready_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (cache_if.cpu_ready === 1'b1) ready_seen++;
        end
        check("rst_no_ready", ready_seen, 0);
        check("rst_idle_bus_req", cache_if.bus_req, 0);

        // Randomized mix of CPU accesses and foreign snoops
        for (int n = 0; n < 150; n++) begin
            a = 8'($urandom_range(0, 3) * LINES + $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) snoop(2'($urandom_range(0, 3)), a);
            else cpu_access(1'($urandom_range(0, 1)), a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
